// File: rtl/proc_pkg.sv
// Shared encodings for the register-transfer controller: command opcodes,
// controller FSM states and the register-index width of the 4-entry file.
package proc_pkg;

    localparam int REG_IDX_W = 2;

    typedef enum logic [1:0] {
        OP_LDI  = 2'd0,
        OP_MOV  = 2'd1,
        OP_ADD  = 2'd2,
        OP_SWAP = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        WR_B = 2'd2,
        WR_A = 2'd3
    } state_e;

endpackage

// File: rtl/register.sv
// Loadable register: captures 'in' on a clock edge when 'store' is high,
// otherwise holds. Clears on reset.
module register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             store,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    // Hold or load the stored word.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; the asynchronous reset sits in the sensitivity list.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else if (store) begin
            out <= in;
        end
    end

endmodule

// File: rtl/regfile_xfer_ctrl.sv
// Register-transfer sequencer for a 4 x WIDTH register file with one read
// mux and one write-strobe demux. Each accepted command (LDI/MOV/ADD/SWAP)
// is stepped through RD_A / WR_B / WR_A so it shares the single read and
// write ports; done pulses the cycle after the final write.
module regfile_xfer_ctrl
    import proc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [REG_IDX_W-1:0] cmd_src,
    input  logic [REG_IDX_W-1:0] cmd_dst,
    input  logic [WIDTH-1:0]     cmd_imm,
    output logic [REG_IDX_W-1:0] rd_sel,
    input  logic [WIDTH-1:0]     rd_data,
    output logic [REG_IDX_W-1:0] wr_sel,
    output logic                 wr_en,
    output logic [WIDTH-1:0]     wr_data,
    output logic                 done,
    output logic                 carry
);

    state_e                 state_q, state_d;
    op_e                    op_q;
    logic [REG_IDX_W-1:0]   src_q, dst_q;
    logic [WIDTH-1:0]       imm_q;
    logic                   carry_q, carry_d;
    logic                   done_q, done_d;
    logic                   tmp_store;
    logic [WIDTH-1:0]       tmp_q;
    logic [WIDTH:0]         sum;
    logic                   accept;

    assign cmd_ready = (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign sum       = {1'b0, tmp_q} + {1'b0, rd_data};
    assign done      = done_q;
    assign carry     = carry_q;

    // First operand holding register, loaded from the read port in RD_A.
    register #(.WIDTH(WIDTH)) u_tmp (
        .clk   (clk),
        .rst   (rst),
        .store (tmp_store),
        .in    (rd_data),
        .out   (tmp_q)
    );

    // State, completion pulse and ADD carry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            carry_q <= carry_d;
        end
    end

    // Capture the command fields on accept; they are ignored while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= OP_LDI;
            src_q <= '0;
            dst_q <= '0;
            imm_q <= '0;
        end else if (accept) begin
            op_q  <= op_e'(cmd_op);
            src_q <= cmd_src;
            dst_q <= cmd_dst;
            imm_q <= cmd_imm;
        end
    end

    // Next-state sequencing and per-state port decode.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d   = state_q;
        rd_sel    = '0;
        wr_sel    = '0;
        wr_en     = 1'b0;
        wr_data   = '0;
        tmp_store = 1'b0;
        carry_d   = carry_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (op_e'(cmd_op))
                        OP_LDI:  state_d = WR_A;
                        OP_MOV:  state_d = WR_B;
                        default: state_d = RD_A;
                    endcase
                end
            end
            RD_A: begin
                tmp_store = 1'b1;
                rd_sel    = (op_q == OP_SWAP) ? src_q : dst_q;
                state_d   = WR_B;
            end
            WR_B: begin
                wr_en = 1'b1;
                if (op_q == OP_SWAP) begin
                    rd_sel  = dst_q;
                    wr_sel  = src_q;
                    wr_data = rd_data;
                    state_d = WR_A;
                end else begin
                    rd_sel  = src_q;
                    wr_sel  = dst_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (op_q == OP_ADD) begin
                        wr_data = sum[WIDTH-1:0];
                        carry_d = sum[WIDTH];
                    end else begin
                        wr_data = rd_data;
                    end
                end
            end
            WR_A: begin
                wr_en   = 1'b1;
                wr_sel  = dst_q;
                wr_data = (op_q == OP_LDI) ? imm_q : tmp_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_xfer_ctrl.sv
// Self-checking bench for regfile_xfer_ctrl. A behavioural register file
// answers the read mux and absorbs writes; a reference model predicts each
// command's writes, busy length, carry and final register contents.
module tb_regfile_xfer_ctrl;

    localparam int WIDTH = 16;
    localparam logic [1:0] LDI = 2'd0, MOV = 2'd1, ADD = 2'd2, SWAP = 2'd3;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [1:0]       cmd_src;
    logic [1:0]       cmd_dst;
    logic [WIDTH-1:0] cmd_imm;
    logic [1:0]       rd_sel;
    logic [WIDTH-1:0] rd_data;
    logic [1:0]       wr_sel;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             done;
    logic             carry;

    regfile_xfer_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_imm   (cmd_imm),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .wr_sel    (wr_sel),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .done      (done),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    // Bench-side register file driven by the DUT's ports.
    logic [WIDTH-1:0] rf [4];
    assign rd_data = rf[rd_sel];
    always @(posedge clk) if (wr_en) rf[wr_sel] <= wr_data;

    // Reference model state.
    logic [WIDTH-1:0] ref_rf [4];
    logic             ref_carry = 1'b0;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Random fields presented while the controller is busy must be ignored.
    task automatic drive_junk();
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_src   = 2'($urandom_range(0, 3));
        cmd_dst   = 2'($urandom_range(0, 3));
        cmd_imm   = 16'($urandom);
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 4; i++) check({tag, "_rf", 8'(48 + i)}, rf[i], ref_rf[i]);
    endtask

    // Entered at a negedge with the controller idle; leaves at the negedge of
    // the done cycle with cmd_valid low, so the next call runs back-to-back.
    task automatic run_cmd(input logic [1:0] op, input logic [1:0] src,
                           input logic [1:0] dst, input logic [WIDTH-1:0] imm);
        logic [1:0]       es [2];
        logic [WIDTH-1:0] ed [2];
        logic [1:0]       er [2];
        int               n_exp, exp_busy;
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] a, b;
        logic [1:0]       ws [4];
        logic [WIDTH-1:0] wd [4];
        logic [1:0]       wr [4];
        int               nw, busy;
        bit               got_done;

        es = '{2'd0, 2'd0}; ed = '{16'd0, 16'd0}; er = '{2'd0, 2'd0};
        case (op)
            LDI: begin
                n_exp = 1; exp_busy = 1;
                es[0] = dst; ed[0] = imm; er[0] = 2'd0;
                ref_rf[dst] = imm;
            end
            MOV: begin
                n_exp = 1; exp_busy = 1;
                es[0] = dst; ed[0] = ref_rf[src]; er[0] = src;
                ref_rf[dst] = ref_rf[src];
            end
            ADD: begin
                n_exp = 2'd1; exp_busy = 2;
                s = {1'b0, ref_rf[dst]} + {1'b0, ref_rf[src]};
                es[0] = dst; ed[0] = s[WIDTH-1:0]; er[0] = src;
                ref_rf[dst] = s[WIDTH-1:0];
                ref_carry = s[WIDTH];
            end
            default: begin
                n_exp = 2; exp_busy = 3;
                a = ref_rf[src]; b = ref_rf[dst];
                es[0] = src; ed[0] = b; er[0] = dst;
                es[1] = dst; ed[1] = a; er[1] = 2'd0;
                ref_rf[src] = b;
                ref_rf[dst] = a;
            end
        endcase

        check("ready_before_accept", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm;
        @(posedge clk);
        #1;
        drive_junk();
        nw = 0; busy = 0; got_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1;
                break;
            end
            if (!cmd_ready) busy++;
            if (wr_en && nw < 4) begin
                ws[nw] = wr_sel; wd[nw] = wr_data; wr[nw] = rd_sel; nw++;
            end
            drive_junk();
        end
        cmd_valid = 1'b0;

        check("done_seen", got_done, 1'b1);
        check("done_ready", cmd_ready, 1'b1);
        check("done_wr_en", wr_en, 1'b0);
        check("done_wr_sel", wr_sel, 2'd0);
        check("done_wr_data", wr_data, 16'd0);
        check("done_rd_sel", rd_sel, 2'd0);
        check("busy_cycles", busy, exp_busy);
        check("write_count", nw, n_exp);
        for (int i = 0; i < n_exp && i < nw; i++) begin
            check("write_sel", ws[i], es[i]);
            check("write_data", wd[i], ed[i]);
            check("write_rd_sel", wr[i], er[i]);
        end
        check("carry", carry, ref_carry);
        check_rf("post");
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_dst = '0; cmd_imm = '0;
        for (int i = 0; i < 4; i++) begin rf[i] = '0; ref_rf[i] = '0; end
        repeat (2) @(negedge clk);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_sel", wr_sel, 2'd0);
        check("rst_rd_sel", rd_sel, 2'd0);
        check("rst_wr_data", wr_data, 16'd0);
        check("rst_done", done, 1'b0);
        check("rst_carry", carry, 1'b0);
        check("rst_tmp", dut.tmp_q, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed scenarios.
        run_cmd(LDI, 2'd0, 2'd2, 16'h1234);
        run_cmd(LDI, 2'd0, 2'd1, 16'hBEEF);
        run_cmd(MOV, 2'd1, 2'd0, 16'h0000);
        run_cmd(LDI, 2'd0, 2'd1, 16'hFFFF);
        run_cmd(LDI, 2'd0, 2'd3, 16'h0002);
        run_cmd(ADD, 2'd3, 2'd1, 16'h0000);
        check("add_wrap_r1", rf[1], 16'h0001);
        check("add_wrap_carry", carry, 1'b1);
        run_cmd(ADD, 2'd1, 2'd1, 16'h0000);
        check("add_clear_carry", carry, 1'b0);
        run_cmd(LDI, 2'd0, 2'd0, 16'hAAAA);
        run_cmd(LDI, 2'd0, 2'd3, 16'h5555);
        run_cmd(SWAP, 2'd3, 2'd0, 16'h0000);
        check("swap_r0", rf[0], 16'h5555);
        check("swap_r3", rf[3], 16'hAAAA);
        run_cmd(SWAP, 2'd2, 2'd2, 16'h0000);
        check("swap_self_r2", rf[2], 16'h1234);

        // Randomised back-to-back commands.
        for (int n = 0; n < 300; n++) begin
            run_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 16'($urandom));
        end

        // Reset during the WR_B cycle of a SWAP, with carry previously set.
        run_cmd(LDI, 2'd0, 2'd0, 16'hFFFF);
        run_cmd(LDI, 2'd0, 2'd1, 16'hFFFF);
        run_cmd(ADD, 2'd0, 2'd1, 16'h0000);
        check("pre_abort_carry", carry, 1'b1);
        cmd_valid = 1'b1; cmd_op = SWAP; cmd_src = 2'd0; cmd_dst = 2'd2; cmd_imm = '0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_wr_b", wr_en, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_wr_en", wr_en, 1'b0);
        check("abort_ready", cmd_ready, 1'b1);
        check("abort_carry", carry, 1'b0);
        check("abort_tmp", dut.tmp_q, 16'd0);
        ref_carry = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_no_done", done, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_done_after", done, 1'b0);
        check_rf("abort");
        run_cmd(LDI, 2'd0, 2'd3, 16'h0F0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_xfer_ctrl.md
# regfile_xfer_ctrl

Sequencer for the 4-entry × 16-bit register file built from `register` instances, a 4:1 read mux and a 1:4 write-strobe demux. It accepts one register-transfer command at a time over a valid/ready handshake. It then drives the read-mux select, write select, write strobe and write data over 1–3 cycles, so that LDI, MOV, ADD and SWAP share the single read port and single write port.

## Interface
- WIDTH, 16, data width of the register file and immediate
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller idle, command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  0=LDI, 1=MOV, 2=ADD, 3=SWAP
- cmd_src  in  2  source register index
- cmd_dst  in  2  destination register index
- cmd_imm  in  WIDTH  immediate for LDI
- rd_sel  out  2  read-mux select
- rd_data  in  WIDTH  read-mux output (combinational from rd_sel)
- wr_sel  out  2  demux select for the store strobe
- wr_en  out  1  store strobe into the demux
- wr_data  out  WIDTH  shared register-file input bus
- done  out  1  one-cycle pulse after a command's final write
- carry  out  1  carry-out of the last ADD

## Operation
- The FSM has states IDLE, RD_A, WR_B and WR_A.
- On accept, op, src, dst and imm are latched. The input fields are ignored while the controller is busy.
- LDI: IDLE → WR_A. In WR_A: wr_sel=dst, wr_data=imm. Busy for 1 cycle.
- MOV: IDLE → WR_B. In WR_B: rd_sel=src, wr_sel=dst, wr_data=rd_data. Busy for 1 cycle.
- ADD: IDLE → RD_A → WR_B.
  - RD_A: rd_sel=dst; tmp ← rd_data.
  - WR_B: rd_sel=src, wr_sel=dst, wr_data=(tmp+rd_data)[WIDTH-1:0]; carry ← bit WIDTH of the sum.
  - Busy for 2 cycles.
- SWAP: IDLE → RD_A → WR_B → WR_A.
  - RD_A: rd_sel=src; tmp ← rd_data.
  - WR_B: rd_sel=dst, wr_sel=src, wr_data=rd_data.
  - WR_A: wr_sel=dst, wr_data=tmp.
  - Busy for 3 cycles.
- wr_en=1 only in WR_A and WR_B.
- Outside write states: wr_sel=0, wr_data=0, wr_en=0. rd_sel=0 except where specified above.
- Arithmetic wraps modulo 2^WIDTH.
- carry changes only on ADD write cycles. LDI, MOV and SWAP hold it.
- src==dst is legal and executes the normal sequence:
  - MOV rewrites the same value.
  - ADD doubles the register.
  - SWAP leaves the register unchanged after 3 cycles.

## Timing
- cmd_ready = (state==IDLE), combinational from the state register.
- Accept at edge E0. The first busy cycle follows E0.
- The final write commits at the edge ending the last busy cycle. done=1 for exactly the following cycle.
- In that done cycle the controller is in IDLE with cmd_ready=1, so back-to-back commands have zero bubble beyond busy cycles.
- Throughput: 1 command per 2 cycles for LDI/MOV, per 3 for ADD, per 4 for SWAP.
- Reset values: state=IDLE, cmd_ready=1, wr_en=0, wr_sel=0, rd_sel=0, wr_data=0, done=0, carry=0, tmp=0, latched fields=0.
- Reset mid-command aborts immediately with no further write strobes. A SWAP aborted after WR_B leaves src overwritten. This is accepted behaviour and not rolled back.
- cmd_valid deasserting while busy has no effect. An accepted command always completes unless reset.

## Structure
- Shared package `proc_pkg` holds:
  - the op encodings OP_LDI/OP_MOV/OP_ADD/OP_SWAP
  - the FSM state encodings
  - REG_IDX_W=2
- tmp is one instance of the existing `register` module:
  - store=1 in RD_A
  - in=rd_data
  - same clk/rst
- FSM, latched fields, carry and output decode live in regfile_xfer_ctrl itself. No other sub-modules.

## Test plan
- LDI: dst=2, imm=0x1234. Expect:
  - cmd_ready low for 1 cycle.
  - wr_en high one cycle with wr_sel=2, wr_data=0x1234.
  - done the next cycle.
  - Bench regfile R2=0x1234.
- MOV: R1=0xBEEF, src=1, dst=0. Expect one write cycle with rd_sel=1, wr_sel=0, wr_data=0xBEEF; then R0=0xBEEF, R1 unchanged.
- ADD wrap: R1=0xFFFF, R3=0x0002, dst=1, src=3. Expect:
  - 2 busy cycles.
  - R1=0x0001 and carry=1.
  - A following ADD of 0x0001+0x0001 clears carry to 0.
- SWAP: R0=0xAAAA, R3=0x5555. Expect:
  - 3 busy cycles with wr_sel sequence 3 then 0 on the two write cycles.
  - Final R0=0x5555, R3=0xAAAA.
  - SWAP src=dst=2 leaves R2 unchanged.
- Back-to-back: cmd_valid held high with LDI then MOV.
  - The second command is accepted in the done cycle of the first.
  - A command presented while busy is not accepted until cmd_ready rises.
- Reset in the WR_B cycle of a SWAP. Expect:
  - wr_en=0 and cmd_ready=1 immediately (asynchronous).
  - done never pulses.
  - tmp and carry are 0.
